// File: rtl/rf_ctx4_32b.sv
// rtl/rf_ctx4_32b.sv - context-sequenced 4x32 register file with serial config chain
//
// Ports:
//   Config_Clock  clock for config shifting and data operation
//   Config_Reset  synchronous active-low reset
//   ConfigEnable  1 = shift config chain, 0 = run
//   ConfigIn      serial config bit in (enters at chain[29])
//   ConfigOut     serial config bit out (chain[0])
//   in            write data from the functional unit
//   out_a         read port A (reg[raddr_a] of the active context)
//   out_b         read port B (reg[raddr_b] of the active context)
//   ctx           active context index
//
// Chain layout: [1:0] = ii_m1, context k at [2+7k +: 7] = {raddr_b, raddr_a, waddr, we}.
module rf_ctx4_32b #(
    parameter int WIDTH = 32
) (
    input  logic             Config_Clock,
    input  logic             Config_Reset,
    input  logic             ConfigEnable,
    input  logic             ConfigIn,
    output logic             ConfigOut,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [1:0]       ctx
);

    logic [29:0]      chain;
    logic [WIDTH-1:0] regs [4];

    logic [1:0] ii_m1;
    logic [6:0] ctx_word;
    logic       we;
    logic [1:0] waddr;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;

    assign ii_m1 = chain[1:0];

    always_comb begin
        ctx_word = chain[8:2];
        case (ctx)
            2'd0:    ctx_word = chain[8:2];
            2'd1:    ctx_word = chain[15:9];
            2'd2:    ctx_word = chain[22:16];
            default: ctx_word = chain[29:23];
        endcase
    end

    assign we      = ctx_word[0];
    assign waddr   = ctx_word[2:1];
    assign raddr_a = ctx_word[4:3];
    assign raddr_b = ctx_word[6:5];

    // Reads come straight from storage, so a same-cycle write is not visible
    // until after the edge.
    assign out_a     = regs[raddr_a];
    assign out_b     = regs[raddr_b];
    assign ConfigOut = chain[0];

    always_ff @(posedge Config_Clock) begin
        if (!Config_Reset) begin
            chain <= '0;
            ctx   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (ConfigEnable) begin
            chain <= {ConfigIn, chain[29:1]};
            ctx   <= 2'd0;
        end else begin
            if (we) begin
                regs[waddr] <= in;
            end
            // A ctx above a freshly lowered ii_m1 keeps counting and wraps at 3.
            ctx <= (ctx == ii_m1) ? 2'd0 : ctx + 2'd1;
        end
    end

endmodule
